// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: mode encodings and the
// weak-taken / weak-not-taken counter seed values.
package bp_defs;

  localparam int BP_STATIC_NT = 0;
  localparam int BP_DYNAMIC   = 1;

  // Smallest counter value whose MSB is set (the first "taken" state).
  function automatic int unsigned weak_taken(input int unsigned bits);
    return 32'd1 << (bits - 1);
  endfunction

  // Largest counter value whose MSB is clear; 0 for a 1-bit counter.
  function automatic int unsigned weak_not_taken(input int unsigned bits);
    return (32'd1 << (bits - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Combinational saturating up/down counter step: returns the next counter
// value for a resolved branch direction, clamped at 0 and all-ones.
module sat_counter #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] ctr,
  input  logic             taken,
  output logic [WIDTH-1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != {WIDTH{1'b1}}) ctr_next = ctr + 1'b1;
    end else begin
      if (ctr != '0) ctr_next = ctr - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters: combinational IF
// lookup, ID-stage update, mispredict redirect and branch statistics.
module branch_predictor
  import bp_defs::*;
#(
  parameter int ENTRIES      = 16,
  parameter int COUNTER_BITS = 2,
  parameter int MODE         = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] correct_pc,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX;
  localparam logic [COUNTER_BITS-1:0] CTR_WT  = COUNTER_BITS'(weak_taken(COUNTER_BITS));
  localparam logic [COUNTER_BITS-1:0] CTR_WNT = COUNTER_BITS'(weak_not_taken(COUNTER_BITS));

  logic                    valid_reg  [ENTRIES];
  logic [TAG_W-1:0]        tag_reg    [ENTRIES];
  logic [31:0]             target_reg [ENTRIES];
  logic [COUNTER_BITS-1:0] ctr_reg    [ENTRIES];
  logic [31:0]             branch_count_reg;
  logic [31:0]             mispredict_count_reg;

  logic [IDX-1:0]          if_idx;
  logic [TAG_W-1:0]        if_tag;
  logic                    if_hit;
  logic [IDX-1:0]          upd_idx;
  logic [TAG_W-1:0]        upd_tag;
  logic                    upd_hit;
  logic [COUNTER_BITS-1:0] ctr_next;

  assign if_idx  = if_pc[IDX+1:2];
  assign if_tag  = if_pc[31:IDX+2];
  assign if_hit  = valid_reg[if_idx] && (tag_reg[if_idx] == if_tag);
  assign upd_idx = upd_pc[IDX+1:2];
  assign upd_tag = upd_pc[31:IDX+2];
  assign upd_hit = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);

  // Lookup reads the table as registered, so a same-cycle update is not bypassed.
  assign pred_taken  = (MODE == BP_DYNAMIC) && if_hit && ctr_reg[if_idx][COUNTER_BITS-1];
  assign pred_target = pred_taken ? target_reg[if_idx] : if_pc + 32'd4;

  assign mispredict = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_pred_target != upd_target)));
  assign correct_pc = upd_taken ? upd_target : upd_pc + 32'd4;

  sat_counter #(
    .WIDTH (COUNTER_BITS)
  ) u_sat_counter (
    .ctr      (ctr_reg[upd_idx]),
    .taken    (upd_taken),
    .ctr_next (ctr_next)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_reg[i]  <= 1'b0;
        tag_reg[i]    <= '0;
        target_reg[i] <= '0;
        ctr_reg[i]    <= CTR_WNT;
      end
      branch_count_reg     <= '0;
      mispredict_count_reg <= '0;
    end else begin
      branch_count_reg     <= branch_count_reg + {31'd0, upd_valid};
      mispredict_count_reg <= mispredict_count_reg + {31'd0, mispredict};
      if (upd_valid && (MODE == BP_DYNAMIC)) begin
        if (upd_hit) begin
          ctr_reg[upd_idx] <= ctr_next;
          if (upd_taken) target_reg[upd_idx] <= upd_target;
        end else if (upd_taken) begin
          // Allocation evicts whatever occupies the slot; aliasing is accepted.
          valid_reg[upd_idx]  <= 1'b1;
          tag_reg[upd_idx]    <= upd_tag;
          target_reg[upd_idx] <= upd_target;
          ctr_reg[upd_idx]    <= CTR_WT;
        end
      end
    end
  end

  assign branch_count     = branch_count_reg;
  assign mispredict_count = mispredict_count_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed vector table, reset corner case, then random
// traffic against an array-based model of the predictor rules.
module tb_branch_predictor;

  localparam int E  = 16;
  localparam int CB = 2;
  localparam int CMAX = (1 << CB) - 1;
  localparam int CWT  = 1 << (CB - 1);
  localparam int CWNT = CWT - 1;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] if_pc;
  logic        upd_valid, upd_taken, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_target;

  logic        pred_taken, mispredict;
  logic [31:0] pred_target, correct_pc, branch_count, mispredict_count;
  logic        s_pred_taken, s_mispredict;
  logic [31:0] s_pred_target, s_correct_pc, s_branch_count, s_mispredict_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(E), .COUNTER_BITS(CB), .MODE(1)) dut (
    .clk(clk), .rstn(rstn), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .correct_pc(correct_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_predictor #(.ENTRIES(E), .COUNTER_BITS(CB), .MODE(0)) dut_s (
    .clk(clk), .rstn(rstn), .if_pc(if_pc),
    .pred_taken(s_pred_taken), .pred_target(s_pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target),
    .mispredict(s_mispredict), .correct_pc(s_correct_pc),
    .branch_count(s_branch_count), .mispredict_count(s_mispredict_count)
  );

  typedef struct {
    logic [31:0] ipc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        upt;
    logic [31:0] uptgt;
    logic        ept;
    logic [31:0] etgt;
    logic        emp;
    logic [31:0] ecpc;
  } vec_t;

  vec_t tbl[19];

  // Behavioural model state: one slot per index, counter kept as a plain int.
  bit          m_valid[E];
  int unsigned m_tag[E];
  logic [31:0] m_tgt[E];
  int          m_ctr[E];
  logic [31:0] m_bc, m_mc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ipc, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt,
                       input logic upt, input logic [31:0] uptgt);
    if_pc = ipc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; upd_pred_taken = upt; upd_pred_target = uptgt;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < E; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = CWNT;
    end
    m_bc = 0; m_mc = 0;
  endfunction

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % E);
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] pc);
    return pc / (4 * E);
  endfunction

  function automatic logic m_pred(input logic [31:0] pc);
    int i = m_idx(pc);
    return m_valid[i] && m_tag[i] == m_tagof(pc) && m_ctr[i] >= CWT;
  endfunction

  function automatic logic m_misp(input logic uv, input logic ut, input logic [31:0] utgt,
                                  input logic upt, input logic [31:0] uptgt);
    return uv && ((ut != upt) || (ut && uptgt != utgt));
  endfunction

  function automatic void model_update();
    int i;
    if (!upd_valid) return;
    m_bc++;
    if (m_misp(upd_valid, upd_taken, upd_target, upd_pred_taken, upd_pred_target)) m_mc++;
    i = m_idx(upd_pc);
    if (m_valid[i] && m_tag[i] == m_tagof(upd_pc)) begin
      if (upd_taken) begin
        m_ctr[i] = (m_ctr[i] + 1 > CMAX) ? CMAX : m_ctr[i] + 1;
        m_tgt[i] = upd_target;
      end else begin
        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (upd_taken) begin
      m_valid[i] = 1; m_tag[i] = m_tagof(upd_pc); m_tgt[i] = upd_target; m_ctr[i] = CWT;
    end
  endfunction

  initial begin
    logic [31:0] ipc, upc, utgt, uptgt, etgt;
    logic uv, ut, upt, ept, emp;

    // Directed sequence: allocate, saturate up, decay, saturate at 0, alias, retarget.
    tbl[0]  = '{32'h00400000, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h00400004, 0, 32'h0};
    tbl[1]  = '{32'h00400010, 1, 32'h00400010, 1, 32'h00400040, 0, 32'h00400014, 0, 32'h00400014, 1, 32'h00400040};
    tbl[2]  = '{32'h00400010, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h00400040, 0, 32'h0};
    tbl[3]  = '{32'h00400010, 1, 32'h00400010, 1, 32'h00400040, 1, 32'h00400040, 1, 32'h00400040, 0, 32'h00400040};
    tbl[4]  = '{32'h00400010, 1, 32'h00400010, 1, 32'h00400040, 1, 32'h00400040, 1, 32'h00400040, 0, 32'h00400040};
    tbl[5]  = '{32'h00400010, 1, 32'h00400010, 0, 32'h00400040, 1, 32'h00400040, 1, 32'h00400040, 1, 32'h00400014};
    tbl[6]  = '{32'h00400010, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h00400040, 0, 32'h0};
    tbl[7]  = '{32'h00400010, 1, 32'h00400010, 0, 32'h00400040, 1, 32'h00400040, 1, 32'h00400040, 1, 32'h00400014};
    tbl[8]  = '{32'h00400010, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h00400014, 0, 32'h0};
    tbl[9]  = '{32'h00400010, 1, 32'h00400010, 0, 32'h00400040, 0, 32'h00400014, 0, 32'h00400014, 0, 32'h00400014};
    tbl[10] = '{32'h00400010, 1, 32'h00400010, 0, 32'h00400040, 0, 32'h00400014, 0, 32'h00400014, 0, 32'h00400014};
    tbl[11] = '{32'h00400010, 1, 32'h00400010, 0, 32'h00400040, 0, 32'h00400014, 0, 32'h00400014, 0, 32'h00400014};
    tbl[12] = '{32'h00400010, 1, 32'h00400010, 1, 32'h00400040, 0, 32'h00400014, 0, 32'h00400014, 1, 32'h00400040};
    tbl[13] = '{32'h00400010, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h00400014, 0, 32'h0};
    tbl[14] = '{32'h00400010, 1, 32'h00400050, 1, 32'h00400080, 0, 32'h00400054, 0, 32'h00400014, 1, 32'h00400080};
    tbl[15] = '{32'h00400010, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h00400014, 0, 32'h0};
    tbl[16] = '{32'h00400050, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h00400080, 0, 32'h0};
    tbl[17] = '{32'h00400050, 1, 32'h00400050, 1, 32'h00400090, 1, 32'h00400080, 1, 32'h00400080, 1, 32'h00400090};
    tbl[18] = '{32'h00400050, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h00400090, 0, 32'h0};

    rstn = 1'b0;
    drive(32'h00400000, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #2;
    chk("reset_branch_count", branch_count, 32'd0);
    chk("reset_mispredict_count", mispredict_count, 32'd0);
    @(negedge clk);

    for (int r = 0; r < 19; r++) begin
      drive(tbl[r].ipc, tbl[r].uv, tbl[r].upc, tbl[r].ut, tbl[r].utgt, tbl[r].upt, tbl[r].uptgt);
      #2;
      chk($sformatf("vec%0d_pred_taken", r), 32'(pred_taken), 32'(tbl[r].ept));
      chk($sformatf("vec%0d_pred_target", r), pred_target, tbl[r].etgt);
      chk($sformatf("vec%0d_mispredict", r), 32'(mispredict), 32'(tbl[r].emp));
      chk($sformatf("vec%0d_static_pred_taken", r), 32'(s_pred_taken), 32'd0);
      chk($sformatf("vec%0d_static_pred_target", r), s_pred_target, tbl[r].ipc + 32'd4);
      if (tbl[r].uv) chk($sformatf("vec%0d_correct_pc", r), correct_pc, tbl[r].ecpc);
      $display("vec %0d: if_pc=%h pred=%0d/%h upd=%0d misp=%0d", r, if_pc, pred_taken,
               pred_target, upd_valid, mispredict);
      @(posedge clk);
      @(negedge clk);
    end
    drive(32'h00400010, 0, 0, 0, 0, 0, 0);
    #2;
    chk("vec_branch_count", branch_count, 32'd11);
    chk("vec_mispredict_count", mispredict_count, 32'd6);
    chk("static_branch_count", s_branch_count, 32'd11);
    chk("static_mispredict_count", s_mispredict_count, 32'd6);

    // Reset asserted while a taken update is presented: nothing may be allocated.
    @(negedge clk);
    drive(32'h00400100, 1, 32'h00400100, 1, 32'h00400200, 0, 32'h00400104);
    #1 rstn = 1'b0;
    #1;
    chk("rst_async_branch_count", branch_count, 32'd0);
    chk("rst_async_pred_taken", 32'(pred_taken), 32'd0);
    @(posedge clk);
    @(negedge clk);
    drive(32'h00400100, 0, 0, 0, 0, 0, 0);
    rstn = 1'b1;
    #2;
    chk("rst_no_alloc_pred_taken", 32'(pred_taken), 32'd0);
    chk("rst_no_alloc_pred_target", pred_target, 32'h00400104);
    chk("rst_branch_count", branch_count, 32'd0);
    chk("rst_mispredict_count", mispredict_count, 32'd0);
    $display("reset-mid-run: pred=%0d bc=%0d mc=%0d", pred_taken, branch_count, mispredict_count);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if_pc = (k == 0) ? 32'h00400010 : 32'h00400050;
      #2;
      chk($sformatf("rst_lookup%0d_pred_taken", k), 32'(pred_taken), 32'd0);
    end
    model_reset();

    // Random traffic over a small PC window so indexes alias and entries get reused.
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      ipc  = 32'h00400000 + ($urandom_range(0, 63) << 2);
      upc  = 32'h00400000 + ($urandom_range(0, 63) << 2);
      uv   = ($urandom_range(0, 3) != 0);
      ut   = $urandom_range(0, 1) == 1;
      utgt = 32'h00410000 + ($urandom_range(0, 7) << 2);
      if ($urandom_range(0, 3) != 0) begin
        upt   = m_pred(upc);
        uptgt = upt ? m_tgt[m_idx(upc)] : upc + 32'd4;
      end else begin
        upt   = $urandom_range(0, 1) == 1;
        uptgt = 32'h00410000 + ($urandom_range(0, 7) << 2);
      end
      drive(ipc, uv, upc, ut, utgt, upt, uptgt);
      #2;
      ept  = m_pred(ipc);
      etgt = ept ? m_tgt[m_idx(ipc)] : ipc + 32'd4;
      emp  = m_misp(uv, ut, utgt, upt, uptgt);
      chk("rnd_pred_taken", 32'(pred_taken), 32'(ept));
      chk("rnd_pred_target", pred_target, etgt);
      chk("rnd_mispredict", 32'(mispredict), 32'(emp));
      if (uv) chk("rnd_correct_pc", correct_pc, ut ? utgt : upc + 32'd4);
      chk("rnd_branch_count", branch_count, m_bc);
      chk("rnd_mispredict_count", mispredict_count, m_mc);
      chk("rnd_static_pred_taken", 32'(s_pred_taken), 32'd0);
      chk("rnd_static_branch_count", s_branch_count, m_bc);
      $display("rnd %0d: if_pc=%h pred=%0d/%h upd=%0d pc=%h t=%0d misp=%0d", n, ipc,
               pred_taken, pred_target, uv, upc, ut, mispredict);
      @(posedge clk);
      model_update();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the 5-stage pipelined MIPS core. It holds a direct-mapped branch target buffer with per-entry saturating counters. In IF it is looked up combinationally with the current PC and supplies the next-fetch prediction. In ID it is updated with the resolved outcome and flags mispredictions so the pipeline can flush IF/ID and redirect. It replaces the always-not-taken behaviour of the current pipeline and is parametrised in table depth, counter width and prediction mode.

## Interface
Parameters:
- ENTRIES, 16: BTB entries; power of 2, 2..256.
- COUNTER_BITS, 2: saturating counter width, 1..4.
- MODE, 1: 0 = static not-taken (table never written), 1 = dynamic.

Ports (one clock, `clk`; reset is asynchronous and active-low, `rstn`):
- clk  in  1: clock; all state updates on posedge.
- rstn  in  1: asynchronous active-low reset.
- if_pc  in  32: fetch PC to predict.
- pred_taken  out  1: prediction for if_pc.
- pred_target  out  32: predicted next PC (target if taken, else if_pc+4).
- upd_valid  in  1: ID holds a resolved conditional branch this cycle.
- upd_pc  in  32: PC of that branch.
- upd_taken  in  1: resolved direction.
- upd_target  in  32: resolved target address.
- upd_pred_taken  in  1: prediction made for that branch in IF.
- upd_pred_target  in  32: predicted target carried with it.
- mispredict  out  1: redirect request.
- correct_pc  out  32: PC to fetch on mispredict.
- branch_count  out  32: resolved branches since reset.
- mispredict_count  out  32: mispredictions since reset.

## Operation
- IDX = log2(ENTRIES). Index = pc[IDX+1:2]. Tag = pc[31:IDX+2]. Each entry holds valid, tag, target[31:0] and ctr[COUNTER_BITS-1:0].
- Hit: the entry at the index is valid and its tag equals the PC tag.
- Lookup (combinational):
  - pred_taken = MODE==1 && hit && ctr MSB == 1.
  - pred_target = pred_taken ? entry.target : if_pc+4.
- mispredict = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_pred_target != upd_target)).
- correct_pc = upd_taken ? upd_target : upd_pc+4. It is driven whenever upd_valid is high.
- Update on posedge with upd_valid and MODE==1:
  - On a hit: ctr increments if taken and decrements if not. It saturates at all-ones and at 0. Target is overwritten with upd_target when taken.
  - On a miss with taken: allocate the entry (overwrite any occupant). Set valid=1, tag, target=upd_target, ctr = weakly taken (2^(COUNTER_BITS-1)).
  - On a miss with not-taken: no change.
- Statistics, on posedge:
  - branch_count += upd_valid.
  - mispredict_count += mispredict.
  - Both wrap modulo 2^32. They count in both modes.

## Timing
- Lookup has 0-cycle latency. Update has 1-cycle latency: a lookup in the same cycle as an update to the same index sees the old entry (no bypass).
- Reset asserted (async):
  - All valid bits clear.
  - All ctr = weakly not-taken (2^(COUNTER_BITS-1)-1, which is 0 for 1-bit).
  - Targets and tags clear.
  - Both statistics counters = 0.
  - With all valid bits clear, the outputs are pred_taken=0, pred_target=if_pc+4, mispredict=0 while upd_valid=0.
- Reset mid-operation: an update presented in the cycle reset asserts is discarded. No state changes while rstn=0.
- While upd_valid=0, upd_* inputs are ignored and no state changes except reset.
- Aliasing: two branches with the same index and different tags thrash a single entry. This is legal; the prediction reflects the last allocated tag.
- COUNTER_BITS=1 degenerates to a 1-bit last-outcome predictor.

## Structure
- A shared package/header `bp_defs` holds the MODE encodings (BP_STATIC_NT=0, BP_DYNAMIC=1) and the weak-taken/weak-not-taken counter constant functions.
- One sub-module: `sat_counter`, combinational, parametrised by width. Inputs are ctr and taken; the output is the next saturated ctr. It is instantiated once, on the update path.
- Table arrays (valid, tag, target, ctr) are flat register arrays in the top module.

## Test plan
- Reset then idle, if_pc=0x00400000 → pred_taken=0, pred_target=0x00400004, both counts 0.
- Update pc=0x00400010, taken, target=0x00400040, pred_taken=0 → mispredict=1, correct_pc=0x00400040. Next cycle lookup at 0x00400010 → pred_taken=1, pred_target=0x00400040, mispredict_count=1.
- 2-bit counter, same branch: taken ×3, then not-taken ×1 → still predicts taken. A second not-taken → predicts not-taken. Three not-taken from 0 → ctr stays 0 (saturation).
- ENTRIES=16: allocate 0x00400010 taken, then 0x00400050 (same index, different tag) taken → lookup at 0x00400010 misses and gives pred_target=0x00400014.
- MODE=0: taken update at 0x00400010 → mispredict=1, and the next lookup still returns pred_taken=0. branch_count=1.
- Assert rstn low mid-run with upd_valid=1 → no allocation. All lookups return not-taken and counts are 0 after release.
